btb_predict_table: RTL and testbench



---
 rtl/btb_pkg.sv | 29 ++
 rtl/dynamic_branch_predictor.sv | 40 ++++
 rtl/btb_predict_table.sv | 150 +++++++++++++++
 tb/tb_btb_predict_table.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btb_pkg
// Description : Shared types and constants for the branch target buffer:
//               2-bit predictor state encoding, allocation/reset states.
// Revision    : 1.0 - initial release
// ============================================================================
package btb_pkg;

    // Bit 1 clear means "predict taken".
    typedef enum logic [1:0] {
        ST_STRONG_T  = 2'b00,
        ST_WEAK_T    = 2'b01,
        ST_STRONG_NT = 2'b10,
        ST_WEAK_NT   = 2'b11
    } btb_state_t;

    // A freshly allocated entry starts weakly taken.
    localparam btb_state_t ST_ALLOC = ST_WEAK_T;
    // Reset leaves every entry strongly not-taken.
    localparam btb_state_t ST_RESET = ST_STRONG_NT;

    // True when the state predicts a taken branch.
    function automatic logic state_predicts_taken(input btb_state_t st);
        return ~st[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dynamic_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : dynamic_branch_predictor
// Description : Next-state function of the 2-bit branch predictor. A
//               mispredict walks ST -> WT -> SNT -> WNT -> ST; a correct
//               prediction strengthens toward the nearest strong state.
// Revision    : 1.0 - initial release
// ============================================================================
module dynamic_branch_predictor
    import btb_pkg::*;
(
    input  btb_state_t state,
    input  logic       mispredicted,
    output btb_state_t next_state
);

    // Transition table selected by the outcome of the resolved branch.
    always_comb begin
        next_state = state;
        if (mispredicted) begin
            unique case (state)
                ST_STRONG_T:  next_state = ST_WEAK_T;
                ST_WEAK_T:    next_state = ST_STRONG_NT;
                ST_STRONG_NT: next_state = ST_WEAK_NT;
                ST_WEAK_NT:   next_state = ST_STRONG_T;
                default:      next_state = state;
            endcase
        end else begin
            unique case (state)
                ST_STRONG_T:  next_state = ST_STRONG_T;
                ST_WEAK_T:    next_state = ST_STRONG_T;
                ST_STRONG_NT: next_state = ST_STRONG_NT;
                ST_WEAK_NT:   next_state = ST_STRONG_NT;
                default:      next_state = state;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/btb_predict_table.sv
`default_nettype none
// ============================================================================
// Module      : btb_predict_table
// Description : Direct-mapped branch target buffer. Combinational lookup for
//               the fetch stage, single resolved-branch update per cycle from
//               execute, global flush. Optional macro BTB_BYPASS_EN forwards a
//               same-cycle update to a lookup of the same index.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_predict_table
    import btb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lkp_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_mispredicted,
    input  logic              flush
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        btb_state_t        state;
    } btb_entry_t;

    // Table storage: valid/state are reset, tag/target are not.
    logic [ENTRIES-1:0] r_valid;
    btb_state_t         r_state  [ENTRIES];
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];

    logic [IDX_W-1:0]   w_upd_idx;
    logic [TAG_W-1:0]   w_upd_tag;
    logic [IDX_W-1:0]   w_lkp_idx;
    logic [TAG_W-1:0]   w_lkp_tag;
    btb_entry_t         w_upd_cur;
    btb_entry_t         w_upd_new;
    btb_entry_t         w_lkp_entry;
    btb_state_t         w_next_state;
    logic               w_upd_hit;
    logic               w_wr_hit;
    logic               w_wr_alloc;
    logic               w_we;
    logic               w_lkp_hit;
    logic               w_unused_bits;

    assign w_upd_idx = upd_pc[IDX_W+1:2];
    assign w_upd_tag = upd_pc[ADDR_W-1:IDX_W+2];
    assign w_lkp_idx = lkp_pc[IDX_W+1:2];
    assign w_lkp_tag = lkp_pc[ADDR_W-1:IDX_W+2];

    // Byte-offset bits never participate in indexing or tagging.
    assign w_unused_bits = ^{lkp_pc[1:0], upd_pc[1:0]};

    // Gather the stored entry addressed by the update port.
    always_comb begin
        w_upd_cur        = '0;
        w_upd_cur.valid  = r_valid[w_upd_idx];
        w_upd_cur.tag    = r_tag[w_upd_idx];
        w_upd_cur.target = r_target[w_upd_idx];
        w_upd_cur.state  = r_state[w_upd_idx];
    end

    assign w_upd_hit = w_upd_cur.valid && (w_upd_cur.tag == w_upd_tag);

    dynamic_branch_predictor u_predictor (
        .state        (w_upd_cur.state),
        .mispredicted (upd_mispredicted),
        .next_state   (w_next_state)
    );

    // Flush wins over a coincident update; not-taken misses never allocate.
    assign w_wr_hit   = upd_valid && !flush && w_upd_hit;
    assign w_wr_alloc = upd_valid && !flush && !w_upd_hit && upd_taken;
    assign w_we       = w_wr_hit || w_wr_alloc;

    // Post-update image of the entry being written.
    always_comb begin
        w_upd_new        = w_upd_cur;
        w_upd_new.valid  = 1'b1;
        w_upd_new.tag    = w_upd_tag;
        if (upd_taken) begin
            w_upd_new.target = upd_target;
        end
        w_upd_new.state  = w_wr_alloc ? ST_ALLOC : w_next_state;
    end

    // Valid and predictor state: asynchronous reset, flush clears valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_state[i] <= ST_RESET;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else if (w_we) begin
            r_valid[w_upd_idx] <= 1'b1;
            r_state[w_upd_idx] <= w_upd_new.state;
        end
    end

    // Tag and target payload carry no reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_tag[w_upd_idx]    <= w_upd_new.tag;
            r_target[w_upd_idx] <= w_upd_new.target;
        end
    end

    // Select the entry seen by the fetch lookup.
    always_comb begin
        w_lkp_entry        = '0;
        w_lkp_entry.valid  = r_valid[w_lkp_idx];
        w_lkp_entry.tag    = r_tag[w_lkp_idx];
        w_lkp_entry.target = r_target[w_lkp_idx];
        w_lkp_entry.state  = r_state[w_lkp_idx];
`ifdef BTB_BYPASS_EN
        if (upd_valid && (w_upd_idx == w_lkp_idx)) begin
            if (flush) begin
                w_lkp_entry.valid = 1'b0;
            end else if (w_we) begin
                w_lkp_entry = w_upd_new;
            end
        end
`endif
    end

    // Outputs are forced to zero while reset is held.
    assign w_lkp_hit   = rst_n && w_lkp_entry.valid && (w_lkp_entry.tag == w_lkp_tag);
    assign pred_hit    = w_lkp_hit;
    assign pred_taken  = w_lkp_hit && state_predicts_taken(w_lkp_entry.state);
    assign pred_target = w_lkp_hit ? w_lkp_entry.target : '0;

endmodule
`default_nettype wire

// File: tb/tb_btb_predict_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_btb_predict_table
// Description : Scoreboard bench for btb_predict_table with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_predict_table;

    localparam int ENTRIES = 16;
    localparam int ADDR_W  = 32;
    localparam int IDX_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] lkp_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_mispredicted;
    logic              flush;

    always #5 clk = ~clk;

    btb_predict_table #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .lkp_pc           (lkp_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_mispredicted (upd_mispredicted),
        .flush            (flush)
    );

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] target;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: per-entry contents, state 0..3 as in the encoding table.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_state  [ENTRIES];
    int          next_mis [4] = '{1, 2, 3, 0};
    int          next_ok  [4] = '{0, 0, 2, 2};

    // Monitor: the lookup outputs are valid every cycle; compare at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (pred_hit !== e.hit || pred_taken !== e.taken || pred_target !== e.target) begin
                n_errors++;
                $display("FAIL %s: hit/taken/target got %b/%b/%h expected %b/%b/%h",
                         e.name, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.target);
            end
        end
    end

    // One cycle of stimulus: apply inputs, push expected lookup, advance model.
    task automatic drive(input string nm, input logic rn, input logic [31:0] lpc,
                         input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt, input logic um, input logic fl);
        int          li, ui, est, nst;
        int unsigned lt, utg, etag;
        logic [31:0] etgt, ntgt;
        bit          ev, we, hit_u;
        exp_t        e;
        @(posedge clk);
        #1;
        rst_n = rn; lkp_pc = lpc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
        upd_target = utgt; upd_mispredicted = um; flush = fl;

        li  = int'((lpc >> 2) % ENTRIES);
        lt  = lpc >> (IDX_W + 2);
        ui  = int'((upc >> 2) % ENTRIES);
        utg = upc >> (IDX_W + 2);

        hit_u = m_valid[ui] && (m_tag[ui] == utg);
        we = 0; nst = 0; ntgt = '0;
        if (rn && uv && !fl) begin
            if (hit_u) begin
                we   = 1;
                nst  = um ? next_mis[m_state[ui]] : next_ok[m_state[ui]];
                ntgt = ut ? utgt : m_target[ui];
            end else if (ut) begin
                we   = 1;
                nst  = 1;
                ntgt = utgt;
            end
        end

        ev = m_valid[li]; etag = m_tag[li]; etgt = m_target[li]; est = m_state[li];
`ifdef BTB_BYPASS_EN
        if (uv && ui == li) begin
            if (fl) ev = 0;
            else if (we) begin
                ev = 1; etag = utg; etgt = ntgt; est = nst;
            end
        end
`endif
        e.hit    = rn && ev && (etag == lt);
        e.taken  = e.hit && (est < 2);
        e.target = e.hit ? etgt : 32'h0;
        e.name   = nm;
        exp_q.push_back(e);

        if (!rn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 0; m_state[i] = 2;
            end
        end else if (fl) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
        end else if (we) begin
            m_valid[ui] = 1; m_tag[ui] = utg; m_target[ui] = ntgt; m_state[ui] = nst;
        end
    endtask

    task automatic look(input string nm, input logic [31:0] lpc);
        drive(nm, 1'b1, lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic upd(input string nm, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic um);
        drive(nm, 1'b1, upc, 1'b1, upc, ut, utgt, um, 1'b0);
    endtask

    initial begin
        logic [31:0] pa, pb;
        rst_n = 1'b0; lkp_pc = '0; upd_valid = 0; upd_pc = '0; upd_taken = 0;
        upd_target = '0; upd_mispredicted = 0; flush = 0;
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = '0; m_state[i] = 2;
        end

        drive("reset_held", 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        look("reset_lookup", 32'h100);
        upd("same_cycle_alloc", 32'h100, 1'b1, 32'h200, 1'b1);
        look("after_alloc", 32'h100);
        upd("taken_correct", 32'h100, 1'b1, 32'h200, 1'b0);
        look("strong_taken", 32'h100);
        upd("mispredict_1", 32'h100, 1'b0, 32'h0, 1'b1);
        upd("mispredict_2", 32'h100, 1'b0, 32'h0, 1'b1);
        look("strong_nt", 32'h100);
        upd("mispredict_3", 32'h100, 1'b0, 32'h0, 1'b1);
        look("weak_nt", 32'h100);
        upd("correct_nt", 32'h100, 1'b0, 32'h0, 1'b0);
        look("back_strong_nt", 32'h100);
        upd("alias_alloc", 32'h140, 1'b1, 32'h300, 1'b1);
        look("alias_old_miss", 32'h100);
        look("alias_new_hit", 32'h140);
        upd("alloc_180", 32'h180, 1'b1, 32'h400, 1'b1);
        look("hit_180", 32'h180);
        drive("flush_with_upd", 1'b1, 32'h180, 1'b1, 32'h180, 1'b1, 32'h500, 1'b0, 1'b1);
        look("flush_miss_180", 32'h180);
        upd("realloc", 32'h204, 1'b1, 32'h600, 1'b1);
        look("realloc_hit", 32'h204);
        drive("reset_mid", 1'b0, 32'h204, 1'b1, 32'h204, 1'b1, 32'h700, 1'b0, 1'b0);
        look("after_reset", 32'h204);

        for (int n = 0; n < 600; n++) begin
            pa = ($urandom_range(0, 3) << (IDX_W + 2)) | ($urandom_range(0, ENTRIES - 1) << 2)
                 | $urandom_range(0, 3);
            pb = ($urandom_range(0, 1) == 0) ? pa :
                 (($urandom_range(0, 3) << (IDX_W + 2)) | ($urandom_range(0, ENTRIES - 1) << 2));
            drive("random", ($urandom_range(0, 99) != 0), pb,
                  ($urandom_range(0, 3) != 0), pa, $urandom_range(0, 1),
                  $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1),
                  ($urandom_range(0, 39) == 0));
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: pending %0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
